rx_packet_ctrl: RTL and testbench
=================================

Name: rx_packet_ctrl

Overview:
Sequences the UART receiver's byte stream into framed command packets. It sits directly behind the rx block and consumes its data_out/finished pair. It hunts for a sync byte, then collects the length, payload and checksum, validates the frame, and holds good payloads in an internal buffer for a host-side reader. Bad frames are dropped and reported with an error code.

Parameters:
MAX_LEN, 16, maximum payload bytes per packet (1..255); also the buffer depth.
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_CYCLES, 100000, clk cycles allowed between bytes inside a frame before the frame is aborted.
AW, $clog2(MAX_LEN), buffer address width (derived, not overridden).

Ports:
clk  in  1  system clock; all logic on its rising edge.
reset  in  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
rx_data  in  8  received byte; valid only while rx_finished=1.
rx_finished  in  1  one-cycle strobe from the receiver: byte available.
pkt_ack  in  1  host has consumed the held packet; releases the buffer.
rd_addr  in  AW  host read address into the payload buffer.
rd_data  out  8  buffer[rd_addr], combinational read.
pkt_ready  out  1  level: a validated packet is held.
pkt_len  out  8  length of the held packet; valid while pkt_ready=1.
err_pulse  out  1  one-cycle strobe: frame rejected.
err_code  out  2  01 = bad length, 10 = checksum, 11 = timeout; holds the last error.
overrun  out  1  sticky: a byte arrived while a packet was held; cleared by pkt_ack or reset.
busy  out  1  high in LEN, PAYLOAD or CHK.

Behaviour:
- Reset values: state=IDLE; pkt_ready, pkt_len, err_pulse, err_code, overrun, busy all 0; timer 0; buffer contents undefined. Reset mid-frame discards the frame without raising an error.
- Frame format: SYNC_BYTE, LEN, LEN payload bytes, CHK. CHK = XOR of LEN and all payload bytes.
- Bytes are acted on only in cycles where rx_finished=1. All registered responses appear the cycle after the strobe.
- IDLE: a byte equal to SYNC_BYTE -> LEN. Any other byte is ignored silently, with no error.
- LEN:
  - LEN=0 or LEN>MAX_LEN -> err_pulse, err_code=01, go to IDLE.
  - Otherwise latch the length, seed the running XOR with LEN, set idx=0, go to PAYLOAD.
- PAYLOAD:
  - Write buffer[idx] = byte, XOR the byte into the running XOR, idx++.
  - When the byte at idx=LEN-1 is written -> CHK.
- CHK:
  - Byte equals the running XOR -> HOLD; pkt_ready=1 and pkt_len=LEN, both visible the cycle after the CHK strobe.
  - Mismatch -> err_pulse, err_code=10, go to IDLE.
- HOLD:
  - The buffer is frozen.
  - A byte arriving with pkt_ack=0 is dropped and sets overrun=1.
  - pkt_ack=1 -> pkt_ready=0, overrun=0, go to IDLE.
  - pkt_ack and rx_finished in the same cycle: the ack wins, and the byte is evaluated as an IDLE byte in that cycle (a sync byte is not lost). overrun is not set.
  - pkt_ack outside HOLD is ignored.
- Timeout:
  - The timer clears on every rx_finished and on entry to LEN. It counts only in LEN, PAYLOAD and CHK.
  - When the timer reaches TIMEOUT_CYCLES-1 with no strobe -> err_pulse, err_code=11, go to IDLE.
  - A strobe in the threshold cycle takes priority over the timeout.
- err_pulse is exactly one cycle wide. err_code keeps its value until the next error.
- rd_data is valid in any state. It is meaningful only for rd_addr<pkt_len while pkt_ready=1.

Decomposition:
- Package uart_pkt_pkg holds:
  - the state encoding IDLE/LEN/PAYLOAD/CHK/HOLD (3 bits);
  - the error code constants ERR_LEN=2'b01, ERR_CHK=2'b10, ERR_TMO=2'b11;
  - the default SYNC_BYTE.
- One sub-module, rx_idle_timer, parameterised by TIMEOUT_CYCLES. Inputs: clear, enable. Output: one-cycle expired pulse.
- Buffer: a plain register array inside rx_packet_ctrl.

Test Plan:
- Good frame: bytes A5 03 11 22 33 03 -> pkt_ready=1 the cycle after the last strobe; pkt_len=3; rd_addr 0/1/2 -> 11/22/33; err_pulse stays 0. Then pkt_ack -> pkt_ready=0.
- Checksum error: A5 02 10 20 00 (expected CHK 0x32) -> err_pulse one cycle, err_code=10, pkt_ready stays 0. A following good frame is accepted.
- Bad length: A5 00 and, separately, A5 11 with MAX_LEN=16 -> err_code=01 each time, return to IDLE. Non-sync garbage 55 FF before A5 produces no error.
- Timeout: A5 02 11, then no strobes for TIMEOUT_CYCLES (set to 50 in the bench) -> err_code=11 on cycle 50 after the last strobe. A strobe at cycle 49 (the threshold cycle) must not time out.
- Overrun and simultaneous ack:
  - While held, send byte 77 with pkt_ack=0 -> overrun=1, buffer unchanged.
  - Then drive pkt_ack=1 together with byte A5 -> pkt_ready=0, overrun=0, state goes to LEN.
- Reset mid-frame: drive reset=0 for one cycle after A5 04 11 -> all outputs 0, no err_pulse. The next frame A5 01 5A 5B (CHK = 01^5A = 5B) is accepted with pkt_len=1.

Source files
------------

// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART packet receive path.
`timescale 1ns/1ps
package uart_pkt_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LEN     = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_CHK     = 3'd3,
      ST_HOLD    = 3'd4
   } pkt_state_t;

   localparam logic [1:0] ERR_LEN = 2'b01;
   localparam logic [1:0] ERR_CHK = 2'b10;
   localparam logic [1:0] ERR_TMO = 2'b11;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] data);
      return acc ^ data;
   endfunction

endpackage

// File: rtl/rx_packet_ctrl_if.sv
// Byte-stream input, host read port and status outputs of the packet controller.
`timescale 1ns/1ps
interface rx_packet_ctrl_if #(parameter int AW = 4);

   logic [7:0]    rx_data;
   logic          rx_finished;
   logic          pkt_ack;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic          pkt_ready;
   logic [7:0]    pkt_len;
   logic          err_pulse;
   logic [1:0]    err_code;
   logic          overrun;
   logic          busy;

   modport master (
      output rx_data, rx_finished, pkt_ack, rd_addr,
      input  rd_data, pkt_ready, pkt_len, err_pulse, err_code, overrun, busy
   );

   modport slave (
      input  rx_data, rx_finished, pkt_ack, rd_addr,
      output rd_data, pkt_ready, pkt_len, err_pulse, err_code, overrun, busy
   );

endinterface

// File: rtl/rx_idle_timer.sv
// Inter-byte watchdog: pulses expired when enabled for TIMEOUT_CYCLES edges without a clear.
`timescale 1ns/1ps
module rx_idle_timer #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   // A strobe in the threshold cycle suppresses the expiry.
   assign expired = enable && !clear && (count == LAST);

   // Idle-cycle counter, held at zero outside an open frame.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= {CW{1'b0}};
      end else if (clear || !enable || expired) begin
         count <= {CW{1'b0}};
      end else begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/rx_packet_ctrl.sv
// Frames the receiver byte stream into SYNC/LEN/payload/CHK packets and holds good payloads for the host.
`timescale 1ns/1ps
module rx_packet_ctrl
   import uart_pkt_pkg::*;
#(
   parameter int         MAX_LEN        = 16,
   parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
   parameter int         TIMEOUT_CYCLES = 100000,
   localparam int        AW             = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
   input logic            clk,
   input logic            reset,
   rx_packet_ctrl_if.slave bus
);

   pkt_state_t state;
   logic [7:0] len;
   logic [7:0] run_xor;
   logic [7:0] idx;
   logic       tmo;
   logic       in_frame;
   logic       buf_we;
   logic [7:0] buffer [0:(1 << AW) - 1];

   assign in_frame = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHK);
   assign buf_we   = bus.rx_finished && (state == ST_PAYLOAD);

   rx_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (bus.rx_finished),
      .enable  (in_frame),
      .expired (tmo)
   );

   // Payload storage; left unwritten outside PAYLOAD so a held packet stays frozen.
   always_ff @(posedge clk) begin
      if (buf_we) begin
         buffer[idx[AW-1:0]] <= bus.rx_data;
      end
   end

   assign bus.rd_data = buffer[bus.rd_addr];

   // Frame sequencer with registered status outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= ST_IDLE;
         len           <= 8'd0;
         run_xor       <= 8'd0;
         idx           <= 8'd0;
         bus.pkt_ready <= 1'b0;
         bus.pkt_len   <= 8'd0;
         bus.err_pulse <= 1'b0;
         bus.err_code  <= 2'b00;
         bus.overrun   <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         bus.err_pulse <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.rx_finished && (bus.rx_data == SYNC_BYTE)) begin
                  state    <= ST_LEN;
                  bus.busy <= 1'b1;
               end
            end
            ST_LEN: begin
               if (bus.rx_finished) begin
                  if ((bus.rx_data == 8'd0) || (bus.rx_data > 8'(MAX_LEN))) begin
                     state         <= ST_IDLE;
                     bus.busy      <= 1'b0;
                     bus.err_pulse <= 1'b1;
                     bus.err_code  <= ERR_LEN;
                  end else begin
                     len     <= bus.rx_data;
                     run_xor <= bus.rx_data;
                     idx     <= 8'd0;
                     state   <= ST_PAYLOAD;
                  end
               end else if (tmo) begin
                  state         <= ST_IDLE;
                  bus.busy      <= 1'b0;
                  bus.err_pulse <= 1'b1;
                  bus.err_code  <= ERR_TMO;
               end
            end
            ST_PAYLOAD: begin
               if (bus.rx_finished) begin
                  run_xor <= xor_fold(run_xor, bus.rx_data);
                  idx     <= idx + 8'd1;
                  if (idx == (len - 8'd1)) begin
                     state <= ST_CHK;
                  end
               end else if (tmo) begin
                  state         <= ST_IDLE;
                  bus.busy      <= 1'b0;
                  bus.err_pulse <= 1'b1;
                  bus.err_code  <= ERR_TMO;
               end
            end
            ST_CHK: begin
               if (bus.rx_finished) begin
                  bus.busy <= 1'b0;
                  if (bus.rx_data == run_xor) begin
                     state         <= ST_HOLD;
                     bus.pkt_ready <= 1'b1;
                     bus.pkt_len   <= len;
                  end else begin
                     state         <= ST_IDLE;
                     bus.err_pulse <= 1'b1;
                     bus.err_code  <= ERR_CHK;
                  end
               end else if (tmo) begin
                  state         <= ST_IDLE;
                  bus.busy      <= 1'b0;
                  bus.err_pulse <= 1'b1;
                  bus.err_code  <= ERR_TMO;
               end
            end
            ST_HOLD: begin
               // The ack wins over a same-cycle byte, which is then treated as an IDLE byte.
               if (bus.pkt_ack) begin
                  bus.pkt_ready <= 1'b0;
                  bus.pkt_len   <= 8'd0;
                  bus.overrun   <= 1'b0;
                  if (bus.rx_finished && (bus.rx_data == SYNC_BYTE)) begin
                     state    <= ST_LEN;
                     bus.busy <= 1'b1;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else if (bus.rx_finished) begin
                  bus.overrun <= 1'b1;
               end
            end
            default: begin
               state    <= ST_IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// Directed bench for rx_packet_ctrl with a scoreboard of expected frame outcomes.
`timescale 1ns/1ps
module tb_rx_packet_ctrl;

   typedef struct packed {
      logic            is_err;
      logic [1:0]      code;
      logic [7:0]      len;
      logic [3:0][7:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   rx_packet_ctrl_if #(.AW(4)) bus ();

   rx_packet_ctrl #(
      .MAX_LEN        (16),
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (50)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; strobe is sampled at the following posedge, returns at the next negedge.
   task automatic send_byte(input logic [7:0] b, input logic ack = 1'b0);
      bus.rx_data     = b;
      bus.rx_finished = 1'b1;
      bus.pkt_ack     = ack;
      @(negedge clk);
      bus.rx_finished = 1'b0;
      bus.pkt_ack     = 1'b0;
      bus.rx_data     = 8'h00;
   endtask

   task automatic ack_pkt();
      bus.pkt_ack = 1'b1;
      @(negedge clk);
      bus.pkt_ack = 1'b0;
   endtask

   function automatic void push_good(input logic [7:0] len, input logic [31:0] bytes);
      exp_t e;
      e.is_err = 1'b0;
      e.code   = 2'b00;
      e.len    = len;
      e.data   = bytes;
      exp_q.push_back(e);
   endfunction

   function automatic void push_err(input logic [1:0] code);
      exp_t e;
      e.is_err = 1'b1;
      e.code   = code;
      e.len    = 8'd0;
      e.data   = 32'd0;
      exp_q.push_back(e);
   endfunction

   task automatic check_result(input string tag);
      exp_t e;
      chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (e.is_err) begin
            chk({tag, "_err_pulse"}, 32'(bus.err_pulse), 32'd1);
            chk({tag, "_err_code"}, 32'(bus.err_code), 32'(e.code));
            chk({tag, "_pkt_ready"}, 32'(bus.pkt_ready), 32'd0);
         end else begin
            chk({tag, "_pkt_ready"}, 32'(bus.pkt_ready), 32'd1);
            chk({tag, "_pkt_len"}, 32'(bus.pkt_len), 32'(e.len));
            chk({tag, "_err_pulse"}, 32'(bus.err_pulse), 32'd0);
            for (int i = 0; i < int'(e.len); i++) begin
               bus.rd_addr = 4'(i);
               #1;
               chk($sformatf("%s_rd%0d", tag, i), 32'(bus.rd_data), 32'(e.data[i]));
            end
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset           = 1'b0;
      bus.rx_data     = 8'h00;
      bus.rx_finished = 1'b0;
      bus.pkt_ack     = 1'b0;
      bus.rd_addr     = 4'd0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      chk("rst_pkt_ready", 32'(bus.pkt_ready), 32'd0);
      chk("rst_pkt_len",   32'(bus.pkt_len),   32'd0);
      chk("rst_err_pulse", 32'(bus.err_pulse), 32'd0);
      chk("rst_err_code",  32'(bus.err_code),  32'd0);
      chk("rst_overrun",   32'(bus.overrun),   32'd0);
      chk("rst_busy",      32'(bus.busy),      32'd0);

      // Good frame
      push_good(8'd3, 32'h00332211);
      send_byte(8'hA5);
      chk("good_busy", 32'(bus.busy), 32'd1);
      send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      chk("good_not_ready_early", 32'(bus.pkt_ready), 32'd0);
      send_byte(8'h03);
      check_result("good");
      chk("good_busy_hold", 32'(bus.busy), 32'd0);
      ack_pkt();
      chk("good_ack_ready", 32'(bus.pkt_ready), 32'd0);

      // Checksum error then a good frame
      push_err(2'b10);
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h00);
      check_result("chkerr");
      @(negedge clk);
      chk("chkerr_pulse_width", 32'(bus.err_pulse), 32'd0);
      chk("chkerr_code_held",   32'(bus.err_code),  32'd2);
      push_good(8'd2, 32'h00002010);
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h32);
      check_result("after_chkerr");
      ack_pkt();

      // Garbage then bad lengths
      send_byte(8'h55); send_byte(8'hFF);
      chk("garbage_err", 32'(bus.err_pulse), 32'd0);
      chk("garbage_busy", 32'(bus.busy), 32'd0);
      push_err(2'b01);
      send_byte(8'hA5); send_byte(8'h00);
      check_result("len0");
      chk("len0_busy", 32'(bus.busy), 32'd0);
      push_err(2'b01);
      send_byte(8'hA5); send_byte(8'h11);
      check_result("len17");

      // Timeout: 50 silent edges after the last strobe
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
      repeat (49) @(negedge clk);
      chk("tmo_early_err", 32'(bus.err_pulse), 32'd0);
      chk("tmo_early_busy", 32'(bus.busy), 32'd1);
      push_err(2'b11);
      @(negedge clk);
      check_result("tmo");
      chk("tmo_busy", 32'(bus.busy), 32'd0);

      // Strobe in the threshold cycle keeps the frame alive
      send_byte(8'hA5); send_byte(8'h01);
      repeat (49) @(negedge clk);
      send_byte(8'h44);
      chk("thr_err", 32'(bus.err_pulse), 32'd0);
      chk("thr_busy", 32'(bus.busy), 32'd1);
      push_good(8'd1, 32'h00000044);
      send_byte(8'h45);
      check_result("thr");
      ack_pkt();

      // Overrun while held, then ack together with a sync byte
      push_good(8'd2, 32'h0000CDAB);
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h64);
      check_result("hold");
      send_byte(8'h77);
      chk("ovr_set", 32'(bus.overrun), 32'd1);
      push_good(8'd2, 32'h0000CDAB);
      check_result("ovr_frozen");
      send_byte(8'hA5, 1'b1);
      chk("ack_sync_ready", 32'(bus.pkt_ready), 32'd0);
      chk("ack_sync_ovr",   32'(bus.overrun),   32'd0);
      chk("ack_sync_busy",  32'(bus.busy),      32'd1);

      // Reset mid-frame
      send_byte(8'h04); send_byte(8'h11);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("mrst_pkt_ready", 32'(bus.pkt_ready), 32'd0);
      chk("mrst_pkt_len",   32'(bus.pkt_len),   32'd0);
      chk("mrst_err_pulse", 32'(bus.err_pulse), 32'd0);
      chk("mrst_err_code",  32'(bus.err_code),  32'd0);
      chk("mrst_overrun",   32'(bus.overrun),   32'd0);
      chk("mrst_busy",      32'(bus.busy),      32'd0);
      push_good(8'd1, 32'h0000005A);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h5A); send_byte(8'h5B);
      check_result("post_rst");
      ack_pkt();
      chk("final_ready", 32'(bus.pkt_ready), 32'd0);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
